// File: rtl/lane_engine.sv
// Lane-generic obstacle engine: N_LANES rotating occupancy masks (cars or logs)
// with registered tile-occupancy render lookup and frog hit/carry status.
module lane_engine #(
  parameter int GAME_WIDTH = 14,
  parameter int N_LANES = 10,
  parameter int FIRST_ROW = 1,
  parameter logic [N_LANES*8-1:0] LANE_PERIOD = {N_LANES{8'd4}},
  parameter logic [N_LANES-1:0] LANE_DIR = '0,
  parameter logic [N_LANES-1:0] LANE_TYPE = '0,
  parameter logic [N_LANES*GAME_WIDTH-1:0] LANE_INIT = {N_LANES{GAME_WIDTH'(32'h0421)}}
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic               i_Tick,
  input  logic [5:0]         i_Frog_X,
  input  logic [5:0]         i_Frog_Y,
  input  logic [4:0]         i_Col_Count_Div,
  input  logic [4:0]         i_Row_Count_Div,
  output logic               o_Obj_Pixel,
  output logic               o_Obj_Type,
  output logic               o_Hit,
  output logic               o_Carry,
  output logic               o_Carry_Dir,
  output logic [N_LANES-1:0] o_Lane_Shift
);

  localparam logic [6:0] ROW0   = 7'(FIRST_ROW);
  localparam logic [6:0] NL7    = 7'(N_LANES);
  localparam logic [6:0] GW7    = 7'(GAME_WIDTH);
  localparam logic [6:0] LAST_X = 7'(GAME_WIDTH - 1);

  logic [6:0] frog_x7, frog_y7, frog_rel;
  logic [6:0] pix_col7, pix_row7, pix_rel;
  logic       frog_in, pix_in, frog_at_left, frog_at_right;

  assign frog_x7  = {1'b0, i_Frog_X};
  assign frog_y7  = {1'b0, i_Frog_Y};
  assign frog_rel = frog_y7 - ROW0;
  assign pix_col7 = {2'b00, i_Col_Count_Div};
  assign pix_row7 = {2'b00, i_Row_Count_Div};
  assign pix_rel  = pix_row7 - ROW0;

  assign frog_in = (frog_y7 >= ROW0) && (frog_rel < NL7) && (frog_x7 < GW7);
  assign pix_in  = (pix_row7 >= ROW0) && (pix_rel < NL7) && (pix_col7 < GW7);
  assign frog_at_left  = (frog_x7 == 7'd0);
  assign frog_at_right = (frog_x7 == LAST_X);

  logic [N_LANES-1:0] shift_now, frog_sel, frog_bit, pix_sel, pix_bit, lead_edge;

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      localparam logic [7:0] PERIOD      = LANE_PERIOD[gi*8 +: 8];
      localparam logic [7:0] PERIOD_LAST = PERIOD - 8'd1;
      localparam logic [GAME_WIDTH-1:0] INIT = LANE_INIT[gi*GAME_WIDTH +: GAME_WIDTH];

      logic [GAME_WIDTH-1:0] mask_reg, mask_rot;
      logic [7:0]            cnt_reg;
      logic                  fbit, pbit;

      if (GAME_WIDTH == 1) begin : g_one
        assign mask_rot = mask_reg;
      end else if (LANE_DIR[gi]) begin : g_left
        assign mask_rot = {mask_reg[0], mask_reg[GAME_WIDTH-1:1]};
      end else begin : g_right
        assign mask_rot = {mask_reg[GAME_WIDTH-2:0], mask_reg[GAME_WIDTH-1]};
      end

      // A zero period makes the lane static: the tick never advances it.
      assign shift_now[gi] = i_Enable && i_Tick && (PERIOD != 8'd0) && (cnt_reg == PERIOD_LAST);

      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          mask_reg <= INIT;
          cnt_reg  <= '0;
        end else if (i_Enable && i_Tick && (PERIOD != 8'd0)) begin
          if (shift_now[gi]) begin
            mask_reg <= mask_rot;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      end

      always_comb begin
        fbit = 1'b0;
        pbit = 1'b0;
        for (int k = 0; k < GAME_WIDTH; k++) begin
          if (frog_x7 == 7'(k)) fbit = mask_reg[k];
          if (pix_col7 == 7'(k)) pbit = mask_reg[k];
        end
      end

      assign frog_bit[gi]  = fbit;
      assign pix_bit[gi]   = pbit;
      assign frog_sel[gi]  = frog_in && (frog_rel == 7'(gi));
      assign pix_sel[gi]   = pix_in && (pix_rel == 7'(gi));
      assign lead_edge[gi] = LANE_DIR[gi] ? frog_at_left : frog_at_right;
    end
  endgenerate

  logic sel_bit, sel_type, sel_dir, sel_shift, sel_edge;
  logic hit_c, carry_c;

  assign sel_bit   = |(frog_sel & frog_bit);
  assign sel_type  = |(frog_sel & LANE_TYPE);
  assign sel_dir   = |(frog_sel & LANE_DIR);
  assign sel_shift = |(frog_sel & shift_now);
  assign sel_edge  = |(frog_sel & lead_edge);

  // A log leaving the playfield sweeps the frog off instead of carrying it.
  assign hit_c   = frog_in && (sel_type ? (~sel_bit || (sel_bit && sel_shift && sel_edge)) : sel_bit);
  assign carry_c = frog_in && sel_type && sel_bit && sel_shift && !sel_edge;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Obj_Pixel  <= 1'b0;
      o_Obj_Type   <= 1'b0;
      o_Hit        <= 1'b0;
      o_Carry      <= 1'b0;
      o_Carry_Dir  <= 1'b0;
      o_Lane_Shift <= '0;
    end else begin
      o_Obj_Pixel  <= pix_in && |(pix_sel & pix_bit);
      o_Obj_Type   <= pix_in && |(pix_sel & LANE_TYPE);
      o_Hit        <= i_Enable && hit_c;
      o_Carry      <= i_Enable && carry_c;
      o_Carry_Dir  <= i_Enable && carry_c && sel_dir;
      o_Lane_Shift <= shift_now;
    end
  end

endmodule

// File: tb/tb_lane_engine.sv
// Directed bench for lane_engine: four lanes (right-moving car P=2, left log P=1,
// right car P=1, static log) exercised through render reads and frog status.
module tb_lane_engine;

  localparam int GW = 14;
  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        tick = 1'b0;
  logic [5:0]  frog_x = 6'd0;
  logic [5:0]  frog_y = 6'd0;
  logic [4:0]  col = 5'd0;
  logic [4:0]  row = 5'd0;
  logic        obj_pixel, obj_type, hit, carry, carry_dir;
  logic [NL-1:0] lane_shift;

  int checks = 0;
  int failures = 0;

  lane_engine #(
    .GAME_WIDTH (GW),
    .N_LANES    (NL),
    .FIRST_ROW  (1),
    .LANE_PERIOD({8'd0, 8'd1, 8'd1, 8'd2}),
    .LANE_DIR   (4'b0010),
    .LANE_TYPE  (4'b1010),
    .LANE_INIT  ({14'h0421, 14'h0001, 14'h0004, 14'h2000})
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Enable       (enable),
    .i_Tick         (tick),
    .i_Frog_X       (frog_x),
    .i_Frog_Y       (frog_y),
    .i_Col_Count_Div(col),
    .i_Row_Count_Div(row),
    .o_Obj_Pixel    (obj_pixel),
    .o_Obj_Type     (obj_type),
    .o_Hit          (hit),
    .o_Carry        (carry),
    .o_Carry_Dir    (carry_dir),
    .o_Lane_Shift   (lane_shift)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_once;
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic read_mask(input int lane, output logic [GW-1:0] m);
    m = '0;
    row = 5'(lane + 1);
    for (int c = 0; c < GW; c++) begin
      col = 5'(c);
      step();
      m[c] = obj_pixel;
    end
    col = 5'd0;
    row = 5'd0;
  endtask

  logic [GW-1:0] m;
  int n0, n2, n3;
  logic acc_hit, acc_shift;

  initial begin
    // Reset and idle render
    step();
    step();
    check("reset_hit", 32'(hit), 32'd0);
    check("reset_carry", 32'(carry), 32'd0);
    check("reset_shift", 32'(lane_shift), 32'd0);
    check("reset_pixel", 32'(obj_pixel), 32'd0);
    rst = 1'b0;

    row = 5'd1; col = 5'd0; step();
    check("render_l0_c0", 32'(obj_pixel), 32'd0);
    col = 5'd13; step();
    check("render_l0_c13", 32'(obj_pixel), 32'd1);
    check("render_l0_type", 32'(obj_type), 32'd0);
    row = 5'd3; col = 5'd0; step();
    check("render_l2_c0", 32'(obj_pixel), 32'd1);
    col = 5'd1; step();
    check("render_l2_c1", 32'(obj_pixel), 32'd0);
    row = 5'd4; col = 5'd14; step();
    check("render_col_oob", 32'(obj_pixel), 32'd0);
    col = 5'd10; step();
    check("render_l3_c10", 32'(obj_pixel), 32'd1);
    check("render_l3_type", 32'(obj_type), 32'd1);
    row = 5'd5; col = 5'd0; step();
    check("render_row_oob", 32'(obj_pixel), 32'd0);
    row = 5'd0;

    // Right wrap on lane 0 (P=2)
    tick_once();
    check("tick1_shift", 32'(lane_shift), 32'h6);
    tick_once();
    check("tick2_shift", 32'(lane_shift), 32'h7);
    step();
    check("shift_one_cycle", 32'(lane_shift), 32'h0);
    read_mask(0, m);
    check("l0_wrap_right", 32'(m), 32'h0001);
    read_mask(1, m);
    check("l1_two_left", 32'(m), 32'h0001);
    read_mask(2, m);
    check("l2_two_right", 32'(m), 32'h0004);
    n0 = 0;
    for (int i = 0; i < 26; i++) begin
      tick_once();
      if (lane_shift[0]) n0++;
    end
    check("l0_pulse_count", 32'(n0), 32'd13);
    read_mask(0, m);
    check("l0_full_cycle", 32'(m), 32'h2000);

    // Car strike on lane 2 (row 3)
    frog_x = 6'd1; frog_y = 6'd3; step();
    check("car_clear", 32'(hit), 32'd0);
    tick_once();
    check("car_pre_shift", 32'(hit), 32'd0);
    step();
    check("car_strike", 32'(hit), 32'd1);
    frog_x = 6'd5; step();
    check("car_dodged", 32'(hit), 32'd0);

    // Log carry and leading edge on lane 1 (row 2, moving left)
    frog_x = 6'd1; frog_y = 6'd2; step();
    check("log_ride_hit", 32'(hit), 32'd0);
    check("log_ride_carry", 32'(carry), 32'd0);
    tick_once();
    check("log_carry", 32'(carry), 32'd1);
    check("log_carry_dir", 32'(carry_dir), 32'd1);
    check("log_carry_hit", 32'(hit), 32'd0);
    frog_x = 6'd0; step();
    check("log_carried_carry", 32'(carry), 32'd0);
    check("log_carried_hit", 32'(hit), 32'd0);
    tick_once();
    check("log_edge_hit", 32'(hit), 32'd1);
    check("log_edge_carry", 32'(carry), 32'd0);

    // Drown on static log lane 3 (row 4), then freeze
    frog_x = 6'd1; frog_y = 6'd4; step();
    check("drown_hit", 32'(hit), 32'd1);
    enable = 1'b0;
    acc_hit = 1'b0; acc_shift = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_once();
      acc_hit = acc_hit | hit | carry;
      acc_shift = acc_shift | (|lane_shift);
    end
    check("freeze_hit", 32'(acc_hit), 32'd0);
    check("freeze_shift", 32'(acc_shift), 32'd0);
    read_mask(1, m);
    check("freeze_l1_mask", 32'(m), 32'h2000);
    read_mask(0, m);
    check("freeze_l0_mask", 32'(m), 32'h0001);
    enable = 1'b1; step();
    check("unfreeze_hit", 32'(hit), 32'd1);
    tick_once();
    check("unfreeze_counter_held", 32'(lane_shift), 32'h7);
    frog_x = 6'd5; step();
    check("static_log_safe", 32'(hit), 32'd0);
    frog_x = 6'd13; step();
    check("frog_last_col", 32'(hit), 32'd1);
    frog_x = 6'd14; step();
    check("frog_col_oob", 32'(hit), 32'd0);
    frog_x = 6'd1; frog_y = 6'd5; step();
    check("frog_row_oob", 32'(hit), 32'd0);
    frog_x = 6'd0; frog_y = 6'd0;

    // Static lane over 100 ticks
    n2 = 0; n3 = 0;
    for (int i = 0; i < 100; i++) begin
      tick_once();
      if (lane_shift[2]) n2++;
      if (lane_shift[3]) n3++;
    end
    check("static_no_pulse", 32'(n3), 32'd0);
    check("l2_pulse_count", 32'(n2), 32'd100);
    read_mask(0, m);
    check("l0_after_100", 32'(m), 32'h0200);
    read_mask(3, m);
    check("l3_static_mask", 32'(m), 32'h0421);

    // Reset coincident with a shifting tick
    rst = 1'b1; tick = 1'b1; step();
    rst = 1'b0; tick = 1'b0;
    check("rst_tick_shift", 32'(lane_shift), 32'h0);
    read_mask(0, m);
    check("rst_l0_init", 32'(m), 32'h2000);
    read_mask(1, m);
    check("rst_l1_init", 32'(m), 32'h0004);
    read_mask(2, m);
    check("rst_l2_init", 32'(m), 32'h0001);
    tick_once();
    check("rst_counter_zero", 32'(lane_shift), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
